// File: rtl/cdc_tx_arbiter.sv
// Round-robin burst arbiter feeding a single-word holding register
// that presents {winner ID, payload} to a clock-domain crossing.
module cdc_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32,
    parameter int IDW    = 2,
    parameter int BURST  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        cfg_enable,
    output logic [IDW+DWIDTH-1:0]  xc_data,
    output logic                   xc_strobe,
    input  logic                   xc_ready,
    output logic [15:0]            xfer_count,
    output logic                   busy
);

    logic                  r_full;
    logic [IDW+DWIDTH-1:0] r_data;
    logic [15:0]           r_cnt;
    logic [3:0]            r_burst;
    logic [IDW-1:0]        r_last;

    logic [NREQ-1:0]       w_elig;
    logic                  w_drain;
    logic                  w_arb;
    logic                  w_rep;
    logic                  w_rr_found;
    logic [IDW-1:0]        w_rr_id;
    int                    w_idx;
    logic                  w_gnt;
    logic [IDW-1:0]        w_gnt_id;
    logic [NREQ-1:0]       w_gnt_oh;
    logic [DWIDTH-1:0]     w_gnt_data;
    logic [3:0]            w_burst_nxt;

    assign w_elig  = req_valid & cfg_enable;
    assign w_drain = r_full & xc_ready;
    assign w_arb   = ~r_full | xc_ready;

    // burst_cnt==0 means no winner yet, so reset starts the search at 0
    assign w_rep = (r_burst != 4'd0) && (r_burst < 4'(BURST)) && w_elig[r_last];

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_id    = r_last;
        w_idx      = 0;
        for (int k = 1; k < NREQ; k++) begin
            w_idx = (int'(r_last) + k) % NREQ;
            if (!w_rr_found && w_elig[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_id    = IDW'(w_idx);
            end
        end
    end

    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = r_last;
        if (w_arb && (|w_elig)) begin
            w_gnt = 1'b1;
            if (w_rep)
                w_gnt_id = r_last;
            else if (w_rr_found)
                w_gnt_id = w_rr_id;
            else
                w_gnt_id = r_last;
        end
    end

    always_comb begin
        w_gnt_oh   = '0;
        w_gnt_data = '0;
        if (w_gnt && rstn)
            w_gnt_oh[w_gnt_id] = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i))
                w_gnt_data = req_data[i*DWIDTH +: DWIDTH];
        end
    end

    always_comb begin
        w_burst_nxt = r_burst + 4'd1;
        if ((w_gnt_id != r_last) || (r_burst >= 4'(BURST)))
            w_burst_nxt = 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_full  <= 1'b0;
            r_data  <= '0;
            r_cnt   <= 16'd0;
            r_burst <= 4'd0;
            r_last  <= IDW'(NREQ - 1);
        end else begin
            if (w_drain)
                r_cnt <= r_cnt + 16'd1;
            if (w_gnt) begin
                r_full  <= 1'b1;
                r_data  <= {w_gnt_id, w_gnt_data};
                r_last  <= w_gnt_id;
                r_burst <= w_burst_nxt;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
        end
    end

    assign req_ready  = w_gnt_oh;
    assign xc_data    = r_data;
    assign xc_strobe  = r_full;
    assign xfer_count = r_cnt;
    assign busy       = r_full | (|w_elig);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Scoreboard bench for cdc_tx_arbiter: NREQ=4, DWIDTH=32, BURST=2.
// Grants are checked per cycle; crossing words are popped and compared.
module tb_cdc_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int IDW   = 2;
    localparam int BURST = 2;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      cfg_enable;
    logic [IDW+DW-1:0]    xc_data;
    logic                 xc_strobe;
    logic                 xc_ready;
    logic [15:0]          xfer_count;
    logic                 busy;

    logic [DW-1:0]        d [NREQ];
    logic [IDW+DW-1:0]    exp_q [$];
    logic [IDW+DW-1:0]    exp_w;
    bit                   sb_on;
    int                   n_vec;
    int                   n_err;

    assign req_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    cdc_tx_arbiter #(
        .NREQ(NREQ), .DWIDTH(DW), .IDW(IDW), .BURST(BURST)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_enable(cfg_enable),
        .xc_data(xc_data), .xc_strobe(xc_strobe),
        .xc_ready(xc_ready), .xfer_count(xfer_count),
        .busy(busy)
    );

    always @(negedge clk) begin
        if (sb_on && rstn === 1'b1 && xc_strobe === 1'b1 && xc_ready === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected got %h want none", xc_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (xc_data !== exp_w) begin
                    n_err++;
                    $display("FAIL sb_word got %h want %h", xc_data, exp_w);
                end
            end
        end
    end

    task automatic to_pos;
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg;
        @(negedge clk);
    endtask

    task automatic do_reset;
        to_pos();
        rstn = 1'b0;
        req_valid = '0;
        to_pos();
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        req_valid = '1;
        cfg_enable = '1;
        xc_ready = 1'b1;
        to_pos();
        to_pos();
        to_neg();
        n_vec++;
        if (req_ready !== 4'b0000) begin
            n_err++; $display("FAIL rst_ready got %b want 0000", req_ready);
        end
        n_vec++;
        if (xc_strobe !== 1'b0) begin
            n_err++; $display("FAIL rst_strobe got %b want 0", xc_strobe);
        end
        n_vec++;
        if (xc_data !== '0) begin
            n_err++; $display("FAIL rst_data got %h want 0", xc_data);
        end
        n_vec++;
        if (xfer_count !== 16'd0) begin
            n_err++; $display("FAIL rst_count got %0d want 0", xfer_count);
        end
        to_pos();
        rstn = 1'b1;
        req_valid = '0;
        to_neg();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL rst_busy got %b want 0", busy);
        end
    endtask

    task automatic test_single;
        to_pos();
        d[0] = 32'hA5A5_0001;
        req_valid = 4'b0001;
        xc_ready = 1'b1;
        to_neg();
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL single_ready got %b want 0001", req_ready);
        end
        exp_q.push_back({2'd0, 32'hA5A5_0001});
        n_vec++;
        if (xc_strobe !== 1'b0) begin
            n_err++; $display("FAIL single_lat got %b want 0", xc_strobe);
        end
        to_pos();
        req_valid = '0;
        to_neg();
        n_vec++;
        if (xc_strobe !== 1'b1 || xc_data !== {2'd0, 32'hA5A5_0001}) begin
            n_err++;
            $display("FAIL single_word got %b/%h want 1/%h",
                     xc_strobe, xc_data, {2'd0, 32'hA5A5_0001});
        end
        to_pos();
        to_neg();
        n_vec++;
        if (xfer_count !== 16'd1 || xc_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL single_cnt got %0d/%b want 1/0", xfer_count, xc_strobe);
        end
    endtask

    task automatic test_burst;
        int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        do_reset();
        cfg_enable = '1;
        xc_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < NREQ; i++)
                d[i] = 32'hB000_0000 + (i << 16) + k;
            req_valid = '1;
            to_neg();
            n_vec++;
            if (req_ready !== 4'(1 << seq[k])) begin
                n_err++;
                $display("FAIL burst_gnt%0d got %b want %b",
                         k, req_ready, 4'(1 << seq[k]));
            end
            exp_q.push_back({IDW'(seq[k]), d[seq[k]]});
            to_pos();
        end
        req_valid = '0;
        to_neg();
        to_pos();
        to_neg();
        n_vec++;
        if (xfer_count !== 16'd9 || xc_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL burst_cnt got %0d/%b want 9/0", xfer_count, xc_strobe);
        end
    endtask

    task automatic test_stall;
        do_reset();
        req_valid = 4'b0010;
        d[1] = 32'h5151_0000;
        xc_ready = 1'b0;
        to_neg();
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL stall_gnt got %b want 0010", req_ready);
        end
        exp_q.push_back({2'd1, 32'h5151_0000});
        for (int s = 0; s < 5; s++) begin
            to_pos();
            d[1] = 32'h5151_0001 + s;
            to_neg();
            n_vec++;
            if (xc_data !== {2'd1, 32'h5151_0000} || req_ready !== 4'b0000 ||
                xfer_count !== 16'd0 || xc_strobe !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold%0d got %h/%b/%0d/%b want %h/0000/0/1",
                         s, xc_data, req_ready, xfer_count, xc_strobe,
                         {2'd1, 32'h5151_0000});
            end
        end
        to_pos();
        xc_ready = 1'b1;
        d[1] = 32'h5151_00FF;
        to_neg();
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++; $display("FAIL stall_reacc got %b want 0010", req_ready);
        end
        exp_q.push_back({2'd1, 32'h5151_00FF});
        to_pos();
        req_valid = '0;
        to_neg();
        n_vec++;
        if (xc_strobe !== 1'b1 || xfer_count !== 16'd1) begin
            n_err++;
            $display("FAIL stall_swap got %b/%0d want 1/1", xc_strobe, xfer_count);
        end
        to_pos();
        to_neg();
        n_vec++;
        if (xfer_count !== 16'd2 || xc_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL stall_cnt got %0d/%b want 2/0", xfer_count, xc_strobe);
        end
    endtask

    task automatic test_enable;
        int seq [8] = '{0, 0, 1, 1, 3, 3, 0, 0};
        do_reset();
        cfg_enable = 4'b1011;
        req_valid = '1;
        xc_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++)
                d[i] = 32'hE000_0000 + (i << 16) + k;
            to_neg();
            n_vec++;
            if (req_ready !== 4'(1 << seq[k])) begin
                n_err++;
                $display("FAIL en_gnt%0d got %b want %b",
                         k, req_ready, 4'(1 << seq[k]));
            end
            exp_q.push_back({IDW'(seq[k]), d[seq[k]]});
            to_pos();
        end
        cfg_enable = 4'b1010;
        req_valid = '0;
        xc_ready = 1'b0;
        to_neg();
        n_vec++;
        if (xc_strobe !== 1'b1 || xc_data[DW+IDW-1:DW] !== 2'd0 ||
            xfer_count !== 16'd7 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL en_held got %b/%0d/%0d/%b want 1/0/7/1",
                     xc_strobe, xc_data[DW+IDW-1:DW], xfer_count, busy);
        end
        to_pos();
        xc_ready = 1'b1;
        to_neg();
        to_pos();
        to_neg();
        n_vec++;
        if (xfer_count !== 16'd8 || xc_strobe !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL en_sent got %0d/%b/%b want 8/0/0",
                     xfer_count, xc_strobe, busy);
        end
    endtask

    task automatic test_reset_mid;
        to_pos();
        cfg_enable = '1;
        req_valid = 4'b0100;
        d[2] = 32'hDEAD_0002;
        xc_ready = 1'b0;
        to_neg();
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++; $display("FAIL mid_gnt got %b want 0100", req_ready);
        end
        to_pos();
        req_valid = '0;
        to_neg();
        n_vec++;
        if (xc_strobe !== 1'b1 || xfer_count !== 16'd8) begin
            n_err++;
            $display("FAIL mid_held got %b/%0d want 1/8", xc_strobe, xfer_count);
        end
        to_pos();
        rstn = 1'b0;
        to_pos();
        rstn = 1'b1;
        req_valid = '1;
        xc_ready = 1'b1;
        d[0] = 32'h0000_C0DE;
        to_neg();
        n_vec++;
        if (xc_strobe !== 1'b0 || xfer_count !== 16'd0 || xc_data !== '0) begin
            n_err++;
            $display("FAIL mid_clr got %b/%0d/%h want 0/0/0",
                     xc_strobe, xfer_count, xc_data);
        end
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++; $display("FAIL mid_first got %b want 0001", req_ready);
        end
        exp_q.push_back({2'd0, 32'h0000_C0DE});
        to_pos();
        req_valid = '0;
        to_neg();
        to_pos();
        to_neg();
        n_vec++;
        if (xfer_count !== 16'd1) begin
            n_err++; $display("FAIL mid_cnt got %0d want 1", xfer_count);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        sb_on = 1'b0;
        cfg_enable = '1;
        req_valid = 4'b0001;
        xc_ready = 1'b1;
        repeat (65536) to_pos();
        req_valid = '0;
        to_neg();
        n_vec++;
        if (xfer_count !== 16'hFFFF || xc_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_max got %h/%b want ffff/1", xfer_count, xc_strobe);
        end
        to_pos();
        to_neg();
        n_vec++;
        if (xfer_count !== 16'h0000 || xc_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_zero got %h/%b want 0000/0", xfer_count, xc_strobe);
        end
        sb_on = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sb_on = 1'b1;
        for (int i = 0; i < NREQ; i++)
            d[i] = '0;
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_enable();
        test_reset_mid();
        test_wrap();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_left got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_tx_arbiter.md
CDC_TX_ARBITER -- requirements
Module: cdc_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DWIDTH, default 32, payload width per requester.
REQ-003 SHALL have parameter IDW, default 2, requester-ID width (ceil(log2(NREQ))).
REQ-004 SHALL have parameter BURST, default 4, max consecutive grants to one requester (1..15).
REQ-005 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port: rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port: req_valid  input  NREQ  per-requester word available.
REQ-008 SHALL have port: req_data  input  NREQ*DWIDTH  payloads; requester i occupies bits [i*DWIDTH +: DWIDTH].
REQ-009 SHALL have port: req_ready  output  NREQ  one-hot accept; a word transfers when req_valid[i] & req_ready[i].
REQ-010 SHALL have port: cfg_enable  input  NREQ  per-requester arbitration enable.
REQ-011 SHALL have port: xc_data  output  IDW+DWIDTH  to crossing: {winner ID, payload}.
REQ-012 SHALL have port: xc_strobe  output  1  held word valid toward crossing.
REQ-013 SHALL have port: xc_ready  input  1  crossing can accept; a word transfers when xc_strobe & xc_ready.
REQ-014 SHALL have port: xfer_count  output  16  completed crossing transfers.
REQ-015 SHALL have port: busy  output  1  high while xc_strobe or any enabled req_valid.

Function
REQ-016 SHALL hold at most one word, in a holding register that drives xc_data/xc_strobe.
REQ-017 SHALL arbitrate in any cycle where the holding register is empty, or is full with xc_strobe & xc_ready.
REQ-018 SHALL consider only requesters with req_valid[i] & cfg_enable[i] as eligible.
REQ-019 SHALL drive req_ready combinationally in the same arbitration cycle; it SHALL be at most one-hot and zero for ineligible requesters.
REQ-020 SHALL load {i, req_data[i]} into the holding register at the next edge when requester i is accepted, and SHALL set xc_strobe=1 (accept-to-strobe latency 1 cycle).
REQ-021 SHALL clear xc_strobe at the edge where xc_strobe & xc_ready and no new word is accepted; simultaneous drain and accept SHALL keep xc_strobe=1 with the new word.
REQ-022 SHALL hold xc_data stable while xc_strobe=1 and xc_ready=0.
REQ-023 SHALL grant the last winner again if it is still eligible and burst_cnt < BURST.
REQ-024 SHALL otherwise grant round-robin, searching from (last winner + 1) mod NREQ upward with wrap, excluding the last winner unless it is the only eligible requester.
REQ-025 SHALL set burst_cnt=1 on a grant to a new requester and increment it on a repeat grant; if the sole eligible requester has burst_cnt=BURST, the grant SHALL proceed and burst_cnt SHALL restart at 1.
REQ-026 SHALL make last winner the granted ID on every grant, and leave it unchanged in cycles without a grant.
REQ-027 SHALL still send a held word whose requester has cfg_enable dropped; enable SHALL affect only future arbitration.
REQ-028 SHALL increment xfer_count on each xc_strobe & xc_ready, wrapping 0xFFFF->0x0000.
REQ-029 SHALL grant nothing and change no state when no requester is eligible and the register is not draining.

Reset
REQ-030 SHALL, while rstn=0 at an edge: xc_strobe=0, xc_data=0, xfer_count=0, burst_cnt=0, last winner=NREQ-1 (requester 0 highest priority first).
REQ-031 SHALL force req_ready=0 while rstn=0.
REQ-032 SHALL discard a held word on reset mid-transfer, with no completion counted.

Verification
REQ-033 SHALL cover: NREQ=4, reset release, req_valid=0001, xc_ready=1 -> req_ready=0001 same cycle, xc_strobe=1 next cycle, xc_data={2'd0,payload}, xfer_count=1.
REQ-034 SHALL cover: all four valid continuously, BURST=2, xc_ready=1 -> grant ID sequence 0,0,1,1,2,2,3,3,0.
REQ-035 SHALL cover: xc_ready=0 for 5 cycles with word held -> xc_data constant, req_ready=0000, xfer_count unchanged; xc_ready=1 -> drain and new accept in the same cycle.
REQ-036 SHALL cover: cfg_enable=1011, all valid -> requester 2 never granted; clear cfg_enable[0] while ID 0 is held -> that word still sent.
REQ-037 SHALL cover: reset asserted with xc_strobe=1 -> next cycle xc_strobe=0, xfer_count=0; first grant after release goes to requester 0.
REQ-038 SHALL cover: 65536 transfers -> xfer_count wraps to 0x0000.
